// File: rtl/frame_token_parser_pkg.sv
// frame_token_types: shared token encodings, parser state encoding and the
// pixel beat record. The frame download stage imports the same token
// constants, so every writer and reader of the pixel queue uses one encoding.
package frame_token_types;

  // Marker tokens have bit 16 set. Pixel tokens have bit 16 clear and carry
  // RGB565 data in [15:0].
  localparam logic [16:0] TOKEN_FRAME_START = 17'h10000;
  localparam logic [16:0] TOKEN_ROW_START   = 17'h10001;
  localparam logic [16:0] TOKEN_FRAME_END   = 17'h1FFFF;

  // Fixed state encodings, kept stable so that netlist probes written for
  // earlier revisions of the parser still decode correctly.
  localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
  localparam logic [1:0] ST_WAIT_ROW   = 2'd1;
  localparam logic [1:0] ST_PIXELS     = 2'd2;

  typedef enum logic [1:0] {
    WAIT_FRAME = ST_WAIT_FRAME,
    WAIT_ROW   = ST_WAIT_ROW,
    PIXELS     = ST_PIXELS
  } t_parser_state;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } t_pixel_beat;

endpackage

// File: rtl/frame_token_parser_skid_buffer.sv
// pixel_skid_buffer: 2-entry valid/ready output buffer for pixel beats.
// Entry 0 is always the head. A push and a pop in the same cycle are both
// honoured. The head holds its data stable while valid and not ready.
//   clk, reset    : clock, asynchronous active-high reset
//   push_i        : write push_beat_i this cycle
//   push_beat_i   : beat to store
//   pop_ready_i   : downstream ready; a pop happens when the head is valid
//   head_valid_o  : head entry holds a beat
//   head_beat_o   : head entry contents
//   count_o       : number of occupied entries (0..2)
module pixel_skid_buffer
  import frame_token_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  t_pixel_beat push_beat_i,
  input  logic        pop_ready_i,
  output logic        head_valid_o,
  output t_pixel_beat head_beat_o,
  output logic [1:0]  count_o
);

  t_pixel_beat entry0_q, entry0_d;
  t_pixel_beat entry1_q, entry1_d;
  logic [1:0]  count_q, count_d;
  logic        pop;
  logic        push_ok;

  assign pop     = pop_ready_i && (count_q != 2'd0);
  // The parser's read throttle never pushes into a full buffer; the guard
  // keeps the count from wrapping should that ever be violated.
  assign push_ok = push_i && ((count_q != 2'd2) || pop);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10: begin
        if (count_q == 2'd0) entry0_d = push_beat_i;
        else                 entry1_d = push_beat_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_d = push_beat_i;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_beat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head_valid_o = (count_q != 2'd0);
  assign head_beat_o  = entry0_q;
  assign count_o      = count_q;

endmodule

// File: rtl/frame_token_parser.sv
// frame_token_parser: turns the 17-bit token stream read from the pixel
// queue into a valid/ready RGB565 pixel stream with sof/eol/eof flags,
// checking the stream against the configured frame geometry.
//   clk, reset          : clock, asynchronous active-high reset
//   queue_empty         : queue has no readable word
//   queue_data_i        : queue read data, valid the cycle after a pop
//   queue_rd_en         : queue pop request
//   pix_ready/pix_valid : downstream handshake
//   pix_data            : RGB565 pixel
//   pix_sof/eol/eof     : first of frame / last of row / last of frame
//   frame_done          : one-cycle pulse on a correct frame end
//   err_row_len         : sticky, a row was cut short by a marker
//   err_seq             : sticky, token out of sequence or illegal
//   err_clear           : synchronous clear of both sticky errors
//
// state      | meaning
// WAIT_FRAME | hunting for frame start; everything else dropped silently
// WAIT_ROW   | between rows; expecting row start or (after last row) frame end
// PIXELS     | inside a row, col counts accepted pixels
module frame_token_parser
  import frame_token_types::*;
#(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        queue_empty,
  input  logic [16:0] queue_data_i,
  output logic        queue_rd_en,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        frame_done,
  output logic        err_row_len,
  output logic        err_seq,
  input  logic        err_clear
);

  localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(FRAME_HEIGHT);

  t_parser_state    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             rd_inflight_q;
  logic             frame_done_q, frame_done_d;
  logic             err_row_len_q, err_row_len_d;
  logic             err_seq_q, err_seq_d;
  logic             set_row_len, set_seq;

  logic             push;
  t_pixel_beat      push_beat;
  logic             buf_valid;
  t_pixel_beat      buf_beat;
  logic [1:0]       buf_count;
  logic             buf_pop;
  logic [1:0]       free_entries;

  logic             is_pixel, is_fs, is_rs, is_fe, is_marker;

  // Free space counts the entry released by this cycle's pop, which is what
  // sustains one pixel per clock with only two entries.
  assign buf_pop      = buf_valid && pix_ready;
  assign free_entries = 2'd2 - buf_count + {1'b0, buf_pop};
  assign queue_rd_en  = !reset && !queue_empty &&
                        (free_entries > {1'b0, rd_inflight_q});

  assign is_pixel  = !queue_data_i[16];
  assign is_fs     = (queue_data_i == TOKEN_FRAME_START);
  assign is_rs     = (queue_data_i == TOKEN_ROW_START);
  assign is_fe     = (queue_data_i == TOKEN_FRAME_END);
  assign is_marker = is_fs || is_rs || is_fe;

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    push           = 1'b0;
    frame_done_d   = 1'b0;
    set_row_len    = 1'b0;
    set_seq        = 1'b0;
    push_beat.data = queue_data_i[15:0];
    push_beat.sof  = (row_q == '0) && (col_q == '0);
    push_beat.eol  = (col_q == COL_LAST);
    push_beat.eof  = (col_q == COL_LAST) && (row_q == ROW_LAST);

    if (rd_inflight_q) begin
      case (state_q)
        WAIT_FRAME: begin
          if (is_fs) begin
            row_d   = '0;
            col_d   = '0;
            state_d = WAIT_ROW;
          end
        end
        WAIT_ROW, PIXELS: begin
          if ((state_q == PIXELS) && is_pixel) begin
            push = 1'b1;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              row_d   = row_q + ROW_W'(1);
              state_d = WAIT_ROW;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            // A marker inside a row truncates it, then is handled exactly
            // as it would be between rows.
            if ((state_q == PIXELS) && is_marker) set_row_len = 1'b1;
            if (is_fs) begin
              set_seq = 1'b1;
              row_d   = '0;
              col_d   = '0;
              state_d = WAIT_ROW;
            end else if (is_rs) begin
              if (row_q < ROW_END) begin
                col_d   = '0;
                state_d = PIXELS;
              end else begin
                set_seq = 1'b1;
                state_d = WAIT_FRAME;
              end
            end else if (is_fe) begin
              if (row_q == ROW_END) frame_done_d = 1'b1;
              else                  set_seq      = 1'b1;
              state_d = WAIT_FRAME;
            end else begin
              // Pixel between rows, or an illegal marker value.
              set_seq = 1'b1;
            end
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end

    err_row_len_d = err_clear ? 1'b0 : (err_row_len_q || set_row_len);
    err_seq_d     = err_clear ? 1'b0 : (err_seq_q || set_seq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_FRAME;
      row_q         <= '0;
      col_q         <= '0;
      rd_inflight_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_row_len_q <= 1'b0;
      err_seq_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      rd_inflight_q <= queue_rd_en;
      frame_done_q  <= frame_done_d;
      err_row_len_q <= err_row_len_d;
      err_seq_q     <= err_seq_d;
    end
  end

  pixel_skid_buffer u_skid (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_beat_i  (push_beat),
    .pop_ready_i  (pix_ready),
    .head_valid_o (buf_valid),
    .head_beat_o  (buf_beat),
    .count_o      (buf_count)
  );

  assign pix_valid   = buf_valid;
  assign pix_data    = buf_beat.data;
  assign pix_sof     = buf_beat.sof;
  assign pix_eol     = buf_beat.eol;
  assign pix_eof     = buf_beat.eof;
  assign frame_done  = frame_done_q;
  assign err_row_len = err_row_len_q;
  assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_frame_token_parser.sv
module tb_frame_token_parser;
  import frame_token_types::*;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        queue_empty = 1'b1;
  logic [16:0] queue_data_i;
  logic        queue_rd_en;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof, pix_eol, pix_eof;
  logic        frame_done;
  logic        err_row_len, err_seq;
  logic        err_clear;

  frame_token_parser #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .queue_empty  (queue_empty),
    .queue_data_i (queue_data_i),
    .queue_rd_en  (queue_rd_en),
    .pix_ready    (pix_ready),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .pix_eof      (pix_eof),
    .frame_done   (frame_done),
    .err_row_len  (err_row_len),
    .err_seq      (err_seq),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] tok;
    bit          beat;
    logic [18:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] tokq[$];
  logic [18:0] sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          px_n = 0;
  int          beats = 0;
  int          fd_count = 0;
  int          cyc = 0;
  int          beat_cyc[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue model: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (queue_rd_en && !queue_empty && tokq.size() > 0)
      queue_data_i <= tokq.pop_front();
  end

  // Output monitor / scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) fd_count++;
      if (pix_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected beat: got data %0h with no beat expected", pix_data);
        end else begin
          chk("beat data/flags", {13'd0, pix_data, pix_sof, pix_eol, pix_eof}, {13'd0, sb[0]});
          if (pix_ready) begin
            void'(sb.pop_front());
            if (beats < 256) beat_cyc[beats] = cyc;
            beats++;
          end
        end
      end
    end
    queue_empty = (tokq.size() == 0);
  end

  task automatic add_tok(input logic [16:0] t);
    vec_t v;
    v.tok = t; v.beat = 1'b0; v.exp = '0;
    tbl.push_back(v);
  endtask

  task automatic add_px(input bit sof, input bit eol, input bit eof);
    vec_t v;
    logic [15:0] d;
    d = 16'hA000 + 16'(px_n);
    px_n++;
    v.tok = {1'b0, d}; v.beat = 1'b1; v.exp = {d, sof, eol, eof};
    tbl.push_back(v);
  endtask

  task automatic add_drop_px(input logic [15:0] d);
    add_tok({1'b0, d});
  endtask

  task automatic add_row(input int row, input int npx);
    add_tok(TOKEN_ROW_START);
    for (int i = 0; i < npx; i++)
      add_px(row == 0 && i == 0, i == W - 1, i == W - 1 && row == H - 1);
  endtask

  task automatic add_frame();
    add_tok(TOKEN_FRAME_START);
    add_row(0, W);
    add_row(1, W);
    add_tok(TOKEN_FRAME_END);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      tokq.push_back(tbl[i].tok);
      if (tbl[i].beat) sb.push_back(tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tokq.size() != 0 || sb.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk({name, " drain in time"}, 32'(n < 500), 32'd1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b0, f0, n;
    reset = 1'b1; pix_ready = 1'b1; err_clear = 1'b0;

    // Reset values, with a readable word present so rd_en gating is tested.
    tokq.push_back(TOKEN_FRAME_START);
    @(negedge clk); #1;
    chk("reset queue_rd_en", queue_rd_en, 0);
    chk("reset pix_valid", pix_valid, 0);
    chk("reset pix_sof", pix_sof, 0);
    chk("reset pix_eol", pix_eol, 0);
    chk("reset pix_eof", pix_eof, 0);
    chk("reset pix_data", pix_data, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset err_row_len", err_row_len, 0);
    chk("reset err_seq", err_seq, 0);
    tokq.delete();
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    // Nominal frame.
    b0 = beats; f0 = fd_count;
    add_frame(); run_table();
    drain("nominal");
    chk("nominal beats", beats - b0, 8);
    chk("nominal frame_done", fd_count - f0, 1);
    chk("nominal err_row_len", err_row_len, 0);
    chk("nominal err_seq", err_seq, 0);
    chk("row throughput", beat_cyc[b0 + 3] - beat_cyc[b0], 3);
    chk("marker overhead", beat_cyc[b0 + 4] - beat_cyc[b0 + 3], 2);

    // Back-pressure mid-row.
    b0 = beats; f0 = fd_count;
    add_frame(); run_table();
    n = 0;
    while (beats < b0 + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("backpressure start in time", 32'(n < 200), 32'd1);
    #1 pix_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    chk("stall queue has words", queue_empty, 0);
    chk("stall queue_rd_en", queue_rd_en, 0);
    chk("stall pix_valid", pix_valid, 1);
    @(posedge clk); #1 pix_ready = 1'b1;
    drain("backpressure");
    chk("backpressure beats", beats - b0, 8);
    chk("backpressure frame_done", fd_count - f0, 1);

    // Short row restarted by row start.
    b0 = beats; f0 = fd_count;
    add_tok(TOKEN_FRAME_START);
    add_row(0, 3);
    add_row(0, W);
    add_row(1, W);
    add_tok(TOKEN_FRAME_END);
    run_table();
    drain("short row");
    chk("short row err_row_len", err_row_len, 1);
    chk("short row beats", beats - b0, 11);
    chk("short row frame_done", fd_count - f0, 1);
    pulse_clear();
    chk("clear err_row_len", err_row_len, 0);
    chk("clear err_seq", err_seq, 0);

    // Pixel in WAIT_ROW.
    f0 = fd_count;
    add_tok(TOKEN_FRAME_START);
    add_drop_px(16'h0ABC);
    add_row(0, W);
    add_row(1, W);
    add_tok(TOKEN_FRAME_END);
    run_table();
    drain("pixel in wait_row");
    chk("wait_row pixel err_seq", err_seq, 1);
    chk("wait_row pixel err_row_len", err_row_len, 0);
    chk("wait_row pixel frame_done", fd_count - f0, 1);
    pulse_clear();
    chk("clear after pixel err_seq", err_seq, 0);

    // Early frame end.
    f0 = fd_count;
    add_tok(TOKEN_FRAME_START);
    add_row(0, W);
    add_tok(TOKEN_FRAME_END);
    run_table();
    drain("early frame end");
    chk("early frame end err_seq", err_seq, 1);
    chk("early frame end frame_done", fd_count - f0, 0);
    pulse_clear();
    chk("clear after early end err_seq", err_seq, 0);
    chk("clear after early end err_row_len", err_row_len, 0);

    // Resynchronisation: garbage before frame start is silent.
    f0 = fd_count;
    add_drop_px(16'h1234);
    add_drop_px(16'h5678);
    add_frame();
    run_table();
    drain("resync");
    chk("resync err_seq", err_seq, 0);
    chk("resync err_row_len", err_row_len, 0);
    chk("resync frame_done", fd_count - f0, 1);

    // Reset mid-row with pixels held in the buffer.
    pix_ready = 1'b0;
    add_tok(TOKEN_FRAME_START);
    add_row(0, 2);
    run_table();
    n = 0;
    while ((!pix_valid || tokq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset pix_valid", pix_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset pix_valid", pix_valid, 0);
    tokq.delete();
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    reset = 1'b0;
    b0 = beats; f0 = fd_count;
    add_frame(); run_table();
    drain("after reset");
    chk("after reset beats", beats - b0, 8);
    chk("after reset frame_done", fd_count - f0, 1);
    chk("after reset err_seq", err_seq, 0);
    chk("after reset err_row_len", err_row_len, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_token_parser.md
# frame_token_parser

Consumes the 17-bit token stream that the frame download stage writes into the pixel queue and converts it into a valid/ready pixel stream with frame and line flags. The token set is frame start, row start, frame end, and RGB565 pixel words. The block sits between the queue read port and the display pixel pipeline. It checks stream structure against the configured frame geometry and reports violations through sticky error flags.

## Interface
Parameters:
- FRAME_WIDTH, 480, pixels per row.
- FRAME_HEIGHT, 272, rows per frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- queue_empty  in  1  queue has no readable word.
- queue_data_i  in  17  queue read data, valid the cycle after an accepted read.
- queue_rd_en  out  1  queue pop request; ignored by the queue when empty.
- pix_ready  in  1  downstream accepts pixel.
- pix_valid  out  1  pixel word present.
- pix_data  out  16  RGB565 pixel.
- pix_sof  out  1  first pixel of frame (row 0, col 0).
- pix_eol  out  1  last pixel of row (col FRAME_WIDTH-1).
- pix_eof  out  1  last pixel of frame (eol and row FRAME_HEIGHT-1).
- frame_done  out  1  one-cycle pulse when a correct frame end token is parsed.
- err_row_len  out  1  sticky; a row was cut short by a marker.
- err_seq  out  1  sticky; token out of sequence.
- err_clear  in  1  synchronous clear of both sticky errors.

## Operation
- Tokens:
  - 17'h10000: frame start.
  - 17'h10001: row start.
  - 17'h1FFFF: frame end.
  - bit16 = 0: pixel, with data in [15:0].
  - Any other value with bit16 = 1 is illegal. It sets err_seq and is dropped.
- States are WAIT_FRAME, WAIT_ROW and PIXELS. The block has a row counter (0..FRAME_HEIGHT) and a col counter (0..FRAME_WIDTH-1).
- WAIT_FRAME:
  - Frame start clears row and col and moves to WAIT_ROW.
  - All other tokens are dropped silently (resynchronisation).
- WAIT_ROW:
  - Row start with row < FRAME_HEIGHT moves to PIXELS with col = 0.
  - Row start with row == FRAME_HEIGHT sets err_seq and moves to WAIT_FRAME.
  - Frame end with row == FRAME_HEIGHT pulses frame_done and moves to WAIT_FRAME.
  - Frame end with row != FRAME_HEIGHT sets err_seq and moves to WAIT_FRAME.
  - A pixel sets err_seq and is dropped.
  - Frame start sets err_seq and restarts the frame.
- PIXELS:
  - Each pixel is pushed into the output buffer with flags computed from row and col, then col increments.
  - At col == FRAME_WIDTH-1: col returns to 0, row increments, and the state moves to WAIT_ROW.
  - Any marker in PIXELS sets err_row_len. The marker is then processed as in WAIT_ROW: frame start restarts the frame, row start restarts the current row at col 0, and frame end goes to WAIT_FRAME.
- Output buffer: 2 entries of {data, sof, eol, eof}.
  - The head of the buffer drives pix_* outputs.
  - A beat transfers when pix_valid && pix_ready.
  - When the buffer is full, pix_valid stays high and the data and flags stay stable until accepted.
- Read throttle: queue_rd_en = !queue_empty && (free_entries > reads_in_flight).
  - At most 1 read is in flight.
  - A marker's read slot is released without occupying an entry.
- err_clear has priority over a same-cycle error set.

## Timing
- Reset values: queue_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, err_row_len and err_seq are all 0; pix_data = 0. State is WAIT_FRAME and both counters are 0.
- Reset mid-frame aborts immediately. The buffer is flushed and parsing restarts at WAIT_FRAME.
- Read latency: a pop issued at cycle t returns data at t+1. The data is parsed in t+1, and a pixel appears on pix_valid at t+2 when the buffer was empty.
- Throughput: 1 pixel per clock when pix_ready is held high and the queue is non-empty.
- Marker overhead: each marker costs one read cycle and no output beat.
- frame_done is registered. It is asserted the cycle after the frame end token's data cycle. The eof pixel may still be held in the buffer at that point.
- Empty queue: queue_rd_en is 0 and no state changes occur.
- A buffer push and pop in the same cycle are both honoured.

## Structure
- Package frame_token_types holds:
  - constants TOKEN_FRAME_START, TOKEN_ROW_START and TOKEN_FRAME_END;
  - the state enum t_parser_state;
  - the typedef t_pixel_beat {data[15:0], sof, eol, eof}.
  - The frame download stage imports the same constants.
- Sub-module pixel_skid_buffer implements the 2-entry valid/ready buffer with count output.

## Test plan
- Nominal frame with FRAME_WIDTH=4 and FRAME_HEIGHT=2: tokens 10000, 10001, 4 pixels, 10001, 4 pixels, 1FFFF.
  - Required: 8 beats.
  - sof on beat 0; eol on beats 3 and 7; eof on beat 7.
  - One frame_done pulse; no errors.
- Back-pressure: hold pix_ready low for 10 cycles mid-row.
  - Required: queue_rd_en stalls after 2 buffered pixels and pix_data is held stable.
  - After release, the pixel order is unchanged and nothing is lost.
- Short row: row of 3 pixels, then 10001.
  - Required: err_row_len = 1 and the row restarts.
  - The next 4 pixels carry eol on the 4th.
- Sequence errors:
  - Pixel 0x00ABC in WAIT_ROW is dropped and sets err_seq.
  - 1FFFF after 1 row (height 2) sets err_seq with no frame_done.
  - err_clear returns both flags to 0.
- Resync and reset:
  - Garbage pixels before 10000 are dropped with no error.
  - reset asserted mid-row clears pix_valid asynchronously, and the next frame parses correctly.
